pwm_duty_capture: RTL and testbench
===================================

Name: pwm_duty_capture

Overview:
Receive-side counterpart of the team's 11-bit PWM generator. It samples an incoming PWM waveform, such as a looped-back motor drive signal or an external sensor PWM, and measures its high time and period in clk cycles. It reports the measured duty on an 11-bit bus with a one-cycle valid strobe. It also detects stuck-low and stuck-high inputs through a timeout.

Parameters:
CNT_W, 11, width of the duty output; the period output is CNT_W+1 bits.
TIMEOUT, 4095, cycle count without a rising edge that declares the input stuck; must be less than 2^(CNT_W+1).
SYNC_STAGES, 2, number of metastability flops on pwm_in; minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pwm_in  in  1  asynchronous PWM input
duty  out  CNT_W  last measured high time in clocks, saturating
period  out  CNT_W+1  last measured rising-to-rising period in clocks
meas_vld  out  1  one-cycle pulse when duty/period/stuck flags update
stuck_lo  out  1  input held low for TIMEOUT cycles
stuck_hi  out  1  input held high for TIMEOUT cycles

Behaviour:
- Input path: pwm_in passes through SYNC_STAGES flops, giving pwm_s. A further flop holds the previous value, pwm_d.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - Both edges see the same delay, so measurements are unaffected by it. Edge detection occurs SYNC_STAGES+1 cycles after the pin changes.
- Counter cnt (CNT_W+1 bits):
  - On a rise cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
- FSM states:
  - WAIT_RISE: after reset or after a timeout.
    - rise -> HIGH.
    - Leaves only on rise; nothing is reported on entry.
  - HIGH:
    - fall -> high_cap <= cnt (equals high time H), go to LOW.
    - cnt == TIMEOUT -> stuck-high report, go to WAIT_RISE.
  - LOW:
    - rise -> period <= cnt (equals P); duty <= min(high_cap, 2^CNT_W-1); meas_vld=1 for that cycle; clear both stuck flags; go to HIGH. The rise starts the next period in the same cycle.
    - cnt == TIMEOUT -> stuck-low report, go to WAIT_RISE.
- Outputs register on the cycle after the detected rise. meas_vld is high for exactly one cycle.
- Stuck-high report: duty <= all-ones, period <= TIMEOUT, stuck_hi <= 1, stuck_lo <= 0, meas_vld pulse.
- Stuck-low report: duty <= 0, period <= TIMEOUT, stuck_lo <= 1, stuck_hi <= 0, meas_vld pulse.
- Stuck flags are sticky until the next complete valid period is reported.
- Timeout counting in WAIT_RISE:
  - If pwm_s is low in WAIT_RISE and cnt reaches TIMEOUT, a stuck-low report is issued once. cnt then saturates and no further pulses are issued until a rise.
  - If pwm_s is high at the time WAIT_RISE is entered, a stuck-high report is issued once in the same way.
  - In short: exactly one report per stuck episode.
- First edge after reset is a fall: ignored (still WAIT_RISE), no report.
- Simultaneous events: rise and timeout in the same cycle means rise wins. Timeout is evaluated on the pre-update cnt.
- Generator compatibility: duty D in 1..2047 at a 2048-cycle period measures as duty=D, period=2048.
  - D=0 gives a constant low input, reported as stuck_lo, duty=0.
- Reset (asynchronous, any time): WAIT_RISE, cnt=0, high_cap=0, duty=0, period=0, meas_vld=0, stuck_lo=0, stuck_hi=0. Sync flops reset to 0.
  - A partial period in progress is discarded.
  - If pwm_in is already high when reset releases, the synchronizer produces a spurious rise. The FSM enters HIGH and the first report carries a truncated high time. The bench must discard the first report after reset.

Optional Feature:
PWM_CAP_FILTER_EN: when defined, a glitch filter sits between pwm_s and the edge detector.
- The filtered level changes only after 3 consecutive identical samples of pwm_s.
- This adds 2 cycles of latency to both edges, so measurements are unchanged.
- High or low pulses shorter than 3 clocks are rejected; a 1- or 2-cycle pulse produces no edges.
- When undefined, pwm_s feeds the edge detector directly and single-cycle pulses are measured (duty=1 is reportable).

Test Plan:
- Generator duty=512, period 2048, free-running -> from the second meas_vld onward: duty=512, period=2048, one pulse every 2048 cycles, stuck flags 0.
- Generator duty=1, then duty=2047 -> duty=1 (filter off) and duty=2047, period=2048. With PWM_CAP_FILTER_EN, duty=1 produces no reports and the input is eventually reported stuck_lo.
- Input held 0 for 5000 cycles after a valid period -> a single meas_vld 4095 cycles after the last rise; duty=0, period=4095, stuck_lo=1. No further pulses. Restarting the PWM clears stuck_lo at the next report.
- Input held 1 for 5000 cycles -> a single meas_vld at cnt=4095 in HIGH; duty=2047, stuck_hi=1.
- rst_n asserted for 3 cycles mid-high-phase -> all outputs 0 immediately. No report for the interrupted period. The first report after reset is discarded; the second report is correct.
- Custom pattern with high 100 and period 300 -> duty=100, period=300. With the filter on, injecting a 1-cycle low glitch inside the high phase leaves duty=100.

Source files
------------

// File: rtl/pwm_duty_capture.sv
// PWM receiver: measures high time and period of an async input in clk cycles.
// Optional glitch filter on the synchronized input: define PWM_CAP_FILTER_EN.
module pwm_duty_capture #(
  parameter int CNT_W       = 11,
  parameter int TIMEOUT     = 4095,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W:0]   period,
  output logic             meas_vld,
  output logic             stuck_lo,
  output logic             stuck_hi
);

  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] TO = PW'(TIMEOUT);
  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_f;
  logic                   pwm_d;
  logic                   rise;
  logic                   fall;
  logic [PW-1:0]          cnt_q;
  logic [PW-1:0]          high_cap;
  logic                   armed_q;
  logic                   armed_n;
  logic                   to_hit;
  logic                   cap_en;
  logic                   rep_ok;
  logic                   rep_lo;
  logic                   rep_hi;

  assign pwm_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic [1:0] hist_q;

  // New level commits only when three samples agree; pwm_d holds the level.
  assign pwm_f = (pwm_s == hist_q[0] && pwm_s == hist_q[1])
               ? pwm_s : pwm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], pwm_s};
    end
  end
`else
  assign pwm_f = pwm_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_d <= 1'b0;
    end else begin
      pwm_d <= pwm_f;
    end
  end

  assign rise   = pwm_f & ~pwm_d;
  assign fall   = ~pwm_f & pwm_d;
  assign to_hit = (cnt_q == TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= PW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_RISE;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_n;
      armed_q <= armed_n;
    end
  end

  // armed_q limits WAIT_RISE to one timeout report per stuck episode.
  always_comb begin
    state_n = state_q;
    armed_n = armed_q;
    cap_en  = 1'b0;
    rep_ok  = 1'b0;
    rep_lo  = 1'b0;
    rep_hi  = 1'b0;
    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_n = HIGH;
          armed_n = 1'b1;
        end else if (armed_q && to_hit) begin
          armed_n = 1'b0;
          rep_hi  = pwm_f;
          rep_lo  = ~pwm_f;
        end
      end
      HIGH: begin
        if (fall) begin
          cap_en  = 1'b1;
          state_n = LOW;
        end else if (to_hit) begin
          rep_hi  = 1'b1;
          armed_n = 1'b0;
          state_n = WAIT_RISE;
        end
      end
      LOW: begin
        if (rise) begin
          rep_ok  = 1'b1;
          state_n = HIGH;
        end else if (to_hit) begin
          rep_lo  = 1'b1;
          armed_n = 1'b0;
          state_n = WAIT_RISE;
        end
      end
      default: begin
        state_n = WAIT_RISE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cap <= '0;
    end else if (cap_en) begin
      high_cap <= cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= '0;
      period   <= '0;
      meas_vld <= 1'b0;
      stuck_lo <= 1'b0;
      stuck_hi <= 1'b0;
    end else begin
      meas_vld <= rep_ok | rep_lo | rep_hi;
      unique case (1'b1)
        rep_ok: begin
          duty     <= (high_cap > {1'b0, DUTY_MAX})
                    ? DUTY_MAX : high_cap[CNT_W-1:0];
          period   <= cnt_q;
          stuck_lo <= 1'b0;
          stuck_hi <= 1'b0;
        end
        rep_hi: begin
          duty     <= DUTY_MAX;
          period   <= TO;
          stuck_lo <= 1'b0;
          stuck_hi <= 1'b1;
        end
        rep_lo: begin
          duty     <= '0;
          period   <= TO;
          stuck_lo <= 1'b1;
          stuck_hi <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: segment-level waveform model predicts every
// report (values and spacing) and compares against captured meas_vld pulses.
module tb_pwm_duty_capture;

  localparam int TO = 4095;
`ifdef PWM_CAP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [10:0] duty;
  logic [11:0] period;
  logic        meas_vld;
  logic        stuck_lo;
  logic        stuck_hi;

  pwm_duty_capture dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .duty(duty),
    .period(period),
    .meas_vld(meas_vld),
    .stuck_lo(stuck_lo),
    .stuck_hi(stuck_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic [11:0] p;
    logic        lo;
    logic        hi;
    longint      at;
  } rep_t;

  rep_t   exp_q[$];
  rep_t   act_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     prev_vld = 1'b0;

  // Model: 0 = waiting for rise, 1 = high, 2 = low; m_t = cycles since rise.
  int     m_st = 0;
  int     m_t = 0;
  int     m_h = 0;
  bit     m_lvl = 1'b0;
  longint m_now = 0;

  always @(negedge clk) begin
    rep_t r;
    cyc++;
    if (rst_n && meas_vld) begin
      n_cmp++;
      if (prev_vld) begin
        n_bad++;
        $display("FAIL vld_width: meas_vld high 2 cycles, required 1");
      end
      r.d  = {1'b0, duty};
      r.p  = period;
      r.lo = stuck_lo;
      r.hi = stuck_hi;
      r.at = cyc;
      act_q.push_back(r);
    end
    prev_vld = meas_vld;
  end

  task automatic push(int d, int p, bit lo, bit hi, longint at);
    rep_t r;
    r.d  = 12'(d);
    r.p  = 12'(p);
    r.lo = lo;
    r.hi = hi;
    r.at = at;
    exp_q.push_back(r);
  endtask

  // Drive pin level for n cycles and advance the model by the same segment.
  task automatic seg(bit pin, int n);
    bit v;
    v = (FILT && n < 3) ? m_lvl : pin;
    if (v != m_lvl) begin
      if (v) begin
        if (m_st == 2) push(m_h > 2047 ? 2047 : m_h, m_t, 1'b0, 1'b0, m_now);
        m_st = 1;
        m_t  = 0;
      end else if (m_st == 1) begin
        m_h  = m_t;
        m_st = 2;
      end
      m_lvl = v;
    end
    if (m_st != 0 && m_t + n > TO) begin
      if (m_st == 1) push(2047, TO, 1'b0, 1'b1, m_now - m_t + TO);
      else push(0, TO, 1'b1, 1'b0, m_now - m_t + TO);
      m_st = 0;
    end
    m_t   += n;
    m_now += n;
    pwm_in = pin;
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm(int h, int p, int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, h);
      seg(1'b0, p - h);
    end
  endtask

  function automatic int nmin();
    return (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_t   = 0;
    m_lvl = 1'b0;
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if ({duty, period} !== 23'd0) begin
      n_bad++;
      $display("FAIL rst_values: duty=%0d period=%0d, required 0/0", duty, period);
    end
    if ({meas_vld, stuck_lo, stuck_hi} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flags: vld/lo/hi=%b, required 000",
               {meas_vld, stuck_lo, stuck_hi});
    end
    rst_n = 1'b1;
    model_reset();
    seg(1'b0, 10);
    n_cmp++;
    if ({duty, period, meas_vld, stuck_lo, stuck_hi} !== 26'd0) begin
      n_bad++;
      $display("FAIL rst_idle: outputs=%h, required 0",
               {duty, period, meas_vld, stuck_lo, stuck_hi});
    end
  endtask

  task automatic test_gen512();
    pwm(512, 2048, 4);
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL g512_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL g512_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL g512_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_extreme_duty();
    pwm(1, 2048, 3);
    pwm(2047, 2048, 3);
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL ext_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL ext_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL ext_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stuck_lo();
    pwm(300, 1000, 2);
    seg(1'b0, 5000);
    n_cmp++;
    if ({stuck_lo, stuck_hi, duty, period} !== {2'b10, 11'd0, 12'd4095}) begin
      n_bad++;
      $display("FAIL slo_outs: lo=%b hi=%b d=%0d p=%0d, want 1 0 0 4095",
               stuck_lo, stuck_hi, duty, period);
    end
    pwm(300, 1000, 3);
    n_cmp++;
    if (stuck_lo !== 1'b0) begin
      n_bad++;
      $display("FAIL slo_clear: stuck_lo=%b, required 0", stuck_lo);
    end
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL slo_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL slo_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL slo_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stuck_hi();
    seg(1'b1, 5000);
    n_cmp++;
    if ({stuck_lo, stuck_hi, duty, period} !== {2'b01, 11'd2047, 12'd4095}) begin
      n_bad++;
      $display("FAIL shi_outs: lo=%b hi=%b d=%0d p=%0d, want 0 1 2047 4095",
               stuck_lo, stuck_hi, duty, period);
    end
    seg(1'b0, 20);
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL shi_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL shi_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL shi_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_high();
    pwm(200, 600, 2);
    seg(1'b1, 50);
    n_cmp++;
    if (act_q.size() != exp_q.size() || act_q.size() == 0 ||
        act_q[act_q.size()-1].d !== exp_q[exp_q.size()-1].d) begin
      n_bad++;
      $display("FAIL mrst_pre: got %0d reports, want %0d", act_q.size(), exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({duty, period, meas_vld, stuck_lo, stuck_hi} !== 26'd0) begin
      n_bad++;
      $display("FAIL mrst_async: outputs=%h, required 0",
               {duty, period, meas_vld, stuck_lo, stuck_hi});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    m_now += 3;
    seg(1'b1, 150);
    seg(1'b0, 400);
    pwm(200, 600, 3);
    seg(m_lvl, 8);
    if (act_q.size() > 0) void'(act_q.pop_front());
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL mrst_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL mrst_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_custom_glitch();
    pwm(100, 300, 2);
    seg(1'b1, 40);
    seg(1'b0, 1);
    seg(1'b1, 59);
    seg(1'b0, 200);
    pwm(100, 300, 2);
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL cust_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL cust_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL cust_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int h;
    int p;
    pwm(2500, 4095, 2);
    for (int k = 0; k < 4; k++) begin
      h = int'($urandom_range(3, 3000));
      p = h + int'($urandom_range(3, 4095 - h));
      pwm(h, p, 2);
    end
    seg(m_lvl, 8);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rnd_count: got %0d, want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < nmin(); i++) begin
      n_cmp++;
      if (act_q[i].d !== exp_q[i].d || act_q[i].p !== exp_q[i].p ||
          act_q[i].lo !== exp_q[i].lo || act_q[i].hi !== exp_q[i].hi) begin
        n_bad++;
        $display("FAIL rnd_rep%0d: got %0d/%0d/%b%b, want %0d/%0d/%b%b", i,
                 act_q[i].d, act_q[i].p, act_q[i].lo, act_q[i].hi,
                 exp_q[i].d, exp_q[i].p, exp_q[i].lo, exp_q[i].hi);
      end
      if (i > 0) begin
        n_cmp++;
        if (act_q[i].at - act_q[i-1].at != exp_q[i].at - exp_q[i-1].at) begin
          n_bad++;
          $display("FAIL rnd_gap%0d: got %0d, want %0d", i,
                   act_q[i].at - act_q[i-1].at, exp_q[i].at - exp_q[i-1].at);
        end
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_gen512();
    test_extreme_duty();
    test_stuck_lo();
    test_stuck_hi();
    test_reset_mid_high();
    test_custom_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
